// File: rtl/kcounter_loop_filter_pkg.sv
// Shared constants, encodings and helpers for the K-counter loop filter.
// Imported by the interface, the counter sub-module and the top level.
package kcounter_loop_filter_pkg;

    localparam int K_SEL_W   = 5;
    localparam int K_SEL_MIN = 2;

    localparam logic DN_UP_UP   = 1'b0;
    localparam logic DN_UP_DOWN = 1'b1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Largest usable exponent: a counter cannot exceed its own width, nor can
    // the exponent exceed what fits in k_sel.
    function automatic int k_sel_max(input int cnt_w);
        return (cnt_w > 31) ? 31 : cnt_w;
    endfunction

    function automatic logic [K_SEL_W-1:0] clamp_k(input logic [K_SEL_W-1:0] k,
                                                    input int kmax);
        int k_int;
        k_int = int'(k);
        if (k_int < K_SEL_MIN) return K_SEL_W'(K_SEL_MIN);
        if (k_int > kmax)      return K_SEL_W'(kmax);
        return k;
    endfunction

endpackage

// File: rtl/kcounter_loop_filter_if.sv
// Control/status bundle between the phase detector side and the loop filter.
// master drives the count qualifiers, slave returns pulses and the exponent.
interface kcounter_loop_filter_if;
    import kcounter_loop_filter_pkg::*;

    logic               enable;
    logic               dn_up;
    logic [K_SEL_W-1:0] k_sel;
    logic               carry;
    logic               borrow;
    logic [K_SEL_W-1:0] k_eff;

    modport master (
        output enable, dn_up, k_sel,
        input  carry, borrow, k_eff
    );

    modport slave (
        input  enable, dn_up, k_sel,
        output carry, borrow, k_eff
    );
endinterface

// File: rtl/kcounter_loop_filter_kmod_counter.sv
// Modulo-2^k_exp counter; wrap flags (combinationally) the increment that
// takes the count from K-1 back to 0.
module kmod_counter
    import kcounter_loop_filter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    input  logic [K_SEL_W-1:0] k_exp,
    output logic               wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_top;
    logic             w_at_top;

    // k_exp == CNT_W shifts the one out entirely, so the subtraction yields all ones.
    assign w_top    = (CNT_W'(1) << k_exp) - CNT_W'(1);
    assign w_at_top = (r_cnt == w_top);
    assign wrap     = inc && w_at_top;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= w_at_top ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/kcounter_loop_filter.sv
// K-counter loop filter: up/down modulo-K counters driven by a phase-detector
// error, emitting registered carry/borrow pulses on wrap.
module kcounter_loop_filter
    import kcounter_loop_filter_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int K_SEL_RST = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    kcounter_loop_filter_if.slave  bus
);

    localparam int                 K_SEL_MAX = k_sel_max(CNT_W);
    localparam logic [K_SEL_W-1:0] K_EFF_RST = clamp_k(K_SEL_W'(K_SEL_RST), K_SEL_MAX);

    state_t             r_state;
    state_t             w_state_next;
    logic [K_SEL_W-1:0] r_k_eff;
    logic               r_carry;
    logic               r_borrow;

    logic [K_SEL_W-1:0] w_k_clamped;
    logic               w_k_change;
    logic               w_clr;
    logic               w_k_load;
    logic               w_count;
    logic               w_inc_up;
    logic               w_inc_dn;
    logic               w_wrap_up;
    logic               w_wrap_dn;

    assign w_k_clamped = clamp_k(bus.k_sel, K_SEL_MAX);
    assign w_k_change  = (w_k_clamped != r_k_eff);

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_k_load     = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            INIT: begin
                // Picking up k_sel here lets counting start on the first RUN cycle.
                w_clr        = 1'b1;
                w_k_load     = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                if (w_k_change) begin
                    w_clr    = 1'b1;
                    w_k_load = 1'b1;
                end else begin
                    w_count  = bus.enable;
                end
            end
            default: w_state_next = INIT;
        endcase
    end

    assign w_inc_up = w_count && (bus.dn_up == DN_UP_UP);
    assign w_inc_dn = w_count && (bus.dn_up == DN_UP_DOWN);

    kmod_counter #(.CNT_W(CNT_W)) u_up (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_inc_up),
        .k_exp (r_k_eff),
        .wrap  (w_wrap_up)
    );

    kmod_counter #(.CNT_W(CNT_W)) u_dn (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_inc_dn),
        .k_exp (r_k_eff),
        .wrap  (w_wrap_dn)
    );

    // Only one counter increments per cycle, so the pulses are mutually exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= INIT;
            r_k_eff  <= K_EFF_RST;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            if (w_k_load) r_k_eff <= w_k_clamped;
            r_carry  <= w_wrap_up;
            r_borrow <= w_wrap_dn;
        end
    end

    assign bus.carry  = r_carry;
    assign bus.borrow = r_borrow;
    assign bus.k_eff  = r_k_eff;

endmodule

// File: doc/kcounter_loop_filter.md
KCOUNTER_LOOP_FILTER -- requirements
Module: kcounter_loop_filter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of each modulus counter.
REQ-002 The block SHALL have parameter K_SEL_RST, default 4, meaning the modulus exponent applied at reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port enable  input  1  count qualifier; when low, the counters hold.
REQ-006 The block SHALL have port dn_up  input  1  phase-detector error: 0 means count up, 1 means count down.
REQ-007 The block SHALL have port k_sel  input  5  modulus exponent, K = 2^k_sel.
REQ-008 The block SHALL have port carry  output  1  one-cycle pulse when the up counter wraps.
REQ-009 The block SHALL have port borrow  output  1  one-cycle pulse when the down counter wraps.
REQ-010 The block SHALL have port k_eff  output  5  clamped modulus exponent currently in use.

Function
REQ-011 The block SHALL contain two independent CNT_W-bit modulo-K counters, up_cnt and dn_cnt.
REQ-012 In each cycle with enable=1, exactly one counter SHALL advance: up_cnt when dn_up=0, dn_cnt when dn_up=1.
REQ-013 Each counter SHALL count 0..K-1, and advancing from K-1 SHALL wrap it to 0.
REQ-014 carry SHALL be asserted in the cycle after up_cnt wraps, for exactly one cycle; borrow SHALL behave the same for dn_cnt.
REQ-015 carry and borrow SHALL be registered outputs and SHALL never be asserted in the same cycle.
REQ-016 When enable=0, both counters SHALL hold, and carry and borrow SHALL be 0 in the following cycle.
REQ-017 k_sel SHALL be clamped to the range 2..CNT_W (K_SEL_MIN..K_SEL_MAX).
REQ-018 k_eff SHALL be a register that holds the clamped value.
REQ-019 When the clamped k_sel differs from k_eff, the block SHALL, in that cycle:
- load k_eff with the new value;
- clear both counters;
- not count;
- assert no carry or borrow in the next cycle.
REQ-020 The block SHALL implement the state machine INIT -> RUN:
- INIT is entered on reset and lasts one cycle, during which counters are cleared and pulses are 0;
- RUN is the counting state;
- a k_sel change does not leave RUN (REQ-019 applies).
REQ-021 Changes on dn_up SHALL take effect in the same cycle they are sampled; no input synchronisation is done inside the block.

Reset
REQ-022 While reset=1 at a clock edge, the block SHALL set up_cnt=0, dn_cnt=0, carry=0, borrow=0, k_eff=clamp(K_SEL_RST), and state=INIT.
REQ-023 Reset asserted mid-count SHALL discard any pending wrap, so that no carry or borrow appears in the cycle after reset.
REQ-024 The block SHALL have no asynchronous reset path.

Structure
REQ-025 A shared package SHALL hold:
- K_SEL_MIN=2;
- K_SEL_MAX derivation;
- DN_UP_UP=0 and DN_UP_DOWN=1 encodings;
- the state enum {INIT, RUN}.
REQ-026 The modulo-K counter SHALL be a single sub-module, kmod_counter, instantiated twice.
- Its ports are clk, reset, clr, inc, k_exp, and wrap.
REQ-027 Clamp and change-detection logic SHALL reside in the top level.
REQ-028 The total RTL size SHALL be 120-400 lines.

Verification
REQ-029 The bench SHALL cover the up-count scenario:
- stimulus: reset, then k_sel=3, enable=1, dn_up=0 for 16 cycles;
- response: carry pulses exactly at cycles 9 and 17 after RUN entry, and borrow stays 0.
REQ-030 The bench SHALL cover the down-count scenario:
- stimulus: k_sel=2, dn_up=1 for 8 cycles;
- response: borrow pulses every 4th count, 2 pulses total, and carry stays 0.
REQ-031 The bench SHALL cover interleaving:
- stimulus: k_sel=2, dn_up alternating 0/1 for 14 cycles;
- response: exactly one carry and one borrow, never coincident.
REQ-032 The bench SHALL cover clamping:
- stimulus: k_sel=0, then k_sel=31;
- response: k_eff=2, then k_eff=CNT_W (16), and counters are cleared on each change.
REQ-033 The bench SHALL cover a k_sel change mid-operation:
- stimulus: k_sel=3 with up_cnt=7, then k_sel changed to 4 on the next edge;
- response: no carry is produced, and the next carry comes 16 counts later.
REQ-034 The bench SHALL cover enable and reset gating:
- stimulus: enable=0 for 10 cycles with up_cnt=7;
- response: no carry; after enable=1, the carry follows one count later;
- stimulus: reset in the cycle of the wrap;
- response: no carry pulse.
